// File: rtl/fft_pkg.sv
// Shared FFT constants, twiddle type and twiddle-sequencer state encoding.
package fft_pkg;
    localparam int N     = 16;
    localparam int TW    = 9;
    localparam int LOG2N = $clog2(N);
    localparam int SW    = $clog2(LOG2N);
    localparam int KW    = LOG2N - 1;

    typedef logic signed [TW-1:0] tw_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } tw_state_t;
endpackage

// File: rtl/tw_rom.sv
// Quarter-wave cosine table C[i] = round(2^(TW-2) * cos(2*pi*i/N)), i = 0..N/4.
module tw_rom
    import fft_pkg::*;
(
    input  logic [KW-1:0] idx_i,
    output tw_t           cos_o
);
    localparam real PI    = 3.14159265358979323846;
    localparam real SCALE = real'(1 << (TW - 2));

    tw_t tbl [0:N/4];

    // Every entry is non-negative, so +0.5 then truncate rounds half away from zero.
    for (genvar i = 0; i <= N / 4; i++) begin : g_tbl
        localparam real ANG = 2.0 * PI * real'(i) / real'(N);
        localparam int  VAL = $rtoi(SCALE * $cos(ANG) + 0.5);
        assign tbl[i] = tw_t'(VAL);
    end

    always_comb begin
        cos_o = '0;
        if (int'(idx_i) <= N / 4) begin
            cos_o = tbl[idx_i];
        end
    end
endmodule

// File: rtl/tw_gen.sv
// Twiddle-factor sequencer for the radix-2 DIF FFT; optional conjugate output under TW_GEN_INV_EN.
module tw_gen
    import fft_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef TW_GEN_INV_EN
    input  logic          inverse,
`endif
    output logic          busy,
    output logic          done,
    output logic          tw_valid,
    input  logic          tw_ready,
    output tw_t           tw_re,
    output tw_t           tw_im,
    output logic [SW-1:0] stage,
    output logic [KW-1:0] bfly_idx
);
    localparam logic [KW-1:0] QTR    = KW'(N / 4);
    localparam logic [KW-1:0] B_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

    tw_state_t     state_q;
    logic          busy_q, done_q, valid_q;
    tw_t           re_q, im_q;
    logic [SW-1:0] stage_q;
    logic [KW-1:0] bfly_q;
    logic          inv_sel;

    logic [SW-1:0] nxt_s_d;
    logic [KW-1:0] nxt_b_d;
    logic [KW-1:0] k, re_idx, im_idx;
    logic          upper;
    tw_t           c_re, c_im, re_d, im_d;

`ifdef TW_GEN_INV_EN
    logic inv_q;
    // The first word is loaded in the same cycle inverse is sampled.
    assign inv_sel = (state_q == ST_IDLE) ? inverse : inv_q;
`else
    assign inv_sel = 1'b0;
`endif

    always_comb begin
        nxt_s_d = '0;
        nxt_b_d = '0;
        if (state_q == ST_RUN) begin
            nxt_b_d = bfly_q + 1'b1;
            nxt_s_d = (bfly_q == B_LAST) ? stage_q + 1'b1 : stage_q;
        end
        // Truncation to KW bits is the mod N/2; N/2 - k likewise wraps to -k.
        k      = nxt_b_d << nxt_s_d;
        upper  = (k > QTR);
        re_idx = upper ? -k : k;
        im_idx = upper ? (k - QTR) : (QTR - k);
        re_d   = upper ? -c_re : c_re;
        im_d   = inv_sel ? c_im : -c_im;
    end

    tw_rom u_rom_re (
        .idx_i (re_idx),
        .cos_o (c_re)
    );

    tw_rom u_rom_im (
        .idx_i (im_idx),
        .cos_o (c_im)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            stage_q <= '0;
            bfly_q  <= '0;
`ifdef TW_GEN_INV_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        stage_q <= nxt_s_d;
                        bfly_q  <= nxt_b_d;
                        re_q    <= re_d;
                        im_q    <= im_d;
`ifdef TW_GEN_INV_EN
                        inv_q   <= inverse;
`endif
                    end
                end
                ST_RUN: begin
                    // valid is always high in RUN, so a load is exactly a handshake.
                    if (valid_q && tw_ready) begin
                        if (stage_q == S_LAST && bfly_q == B_LAST) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            stage_q <= nxt_s_d;
                            bfly_q  <= nxt_b_d;
                            re_q    <= re_d;
                            im_q    <= im_d;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign tw_valid = valid_q;
    assign tw_re    = re_q;
    assign tw_im    = im_q;
    assign stage    = stage_q;
    assign bfly_idx = bfly_q;
endmodule

// File: tb/tb_tw_gen.sv
// Directed bench for tw_gen at N=16, TW=9; the inverse case runs when TW_GEN_INV_EN is defined.
module tb_tw_gen;
    logic              clk = 1'b0;
    logic              rst, start, tw_ready;
    logic              busy, done, tw_valid;
    logic signed [8:0] tw_re, tw_im;
    logic        [1:0] stage;
    logic        [2:0] bfly_idx;
`ifdef TW_GEN_INV_EN
    logic              inverse;
`endif

    int errors = 0;
    int checks = 0;

    // Forward twiddle per exponent k = 0..7, from C = {128, 118, 91, 49, 0}.
    int exp_re [8] = '{128, 118, 91, 49, 0, -49, -91, -118};
    int exp_im [8] = '{0, -49, -91, -118, -128, -118, -91, -49};

    tw_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
`ifdef TW_GEN_INV_EN
        .inverse  (inverse),
`endif
        .busy     (busy),
        .done     (done),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .tw_re    (tw_re),
        .tw_im    (tw_im),
        .stage    (stage),
        .bfly_idx (bfly_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, int'(tw_valid), 0);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_done"},  int'(done), 0);
        check({tag, "_re"},    int'(tw_re), 0);
        check({tag, "_im"},    int'(tw_im), 0);
        check({tag, "_stage"}, int'(stage), 0);
        check({tag, "_bfly"},  int'(bfly_idx), 0);
    endtask

    // Runs one sequence from IDLE; stall_n stalls 3 cycles on that word, rst_n resets
    // before that word's handshake, restart_n pulses start while busy.
    task automatic run_seq(input int stall_n, input int rst_n, input int restart_n,
                           input bit inv, output int nwords, output int ndone);
        int  stall, last_hs, s, b, k, eim;
        bit  restarted;
        nwords = 0;
        ndone = 0;
        stall = 0;
        last_hs = -10;
        restarted = 1'b0;
`ifdef TW_GEN_INV_EN
        inverse = inv;
`endif
        tw_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
`ifdef TW_GEN_INV_EN
        inverse = 1'b0;
`endif
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (cyc == 0) begin
                check("first_valid", int'(tw_valid), 1);
                check("first_busy", int'(busy), 1);
            end
            if (done) begin
                ndone++;
                check("done_lat", cyc, last_hs + 1);
                check("done_words", nwords, 32);
                check("done_valid", int'(tw_valid), 0);
                check("done_busy", int'(busy), 0);
            end
            if (rst_n >= 0 && nwords == rst_n && tw_valid) begin
                rst = 1'b1;
                #1;
                check_zero("midrst");
                break;
            end
            if (tw_valid) begin
                if (nwords == stall_n && stall < 3) begin
                    tw_ready = 1'b0;
                    stall++;
                    check($sformatf("hold%0d_re", stall), int'(tw_re), 49);
                    check($sformatf("hold%0d_im", stall), int'(tw_im), -118);
                    check($sformatf("hold%0d_valid", stall), int'(tw_valid), 1);
                    check($sformatf("hold%0d_bfly", stall), int'(bfly_idx), 3);
                end else begin
                    tw_ready = 1'b1;
                    s = nwords / 8;
                    b = nwords % 8;
                    k = (b << s) % 8;
                    eim = inv ? -exp_im[k] : exp_im[k];
                    check($sformatf("stage[%0d]", nwords), int'(stage), s);
                    check($sformatf("bfly[%0d]", nwords), int'(bfly_idx), b);
                    check($sformatf("re[%0d]", nwords), int'(tw_re), exp_re[k]);
                    check($sformatf("im[%0d]", nwords), int'(tw_im), eim);
                    last_hs = cyc;
                    nwords++;
                end
            end
            if (restart_n >= 0 && nwords == restart_n && !restarted) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (ndone > 0 && cyc >= last_hs + 3) break;
            step();
            start = 1'b0;
        end
    endtask

    initial begin
        int nw, nd;
        rst = 1'b1;
        start = 1'b0;
        tw_ready = 1'b0;
`ifdef TW_GEN_INV_EN
        inverse = 1'b0;
`endif
        step();
        step();
        check_zero("reset");
        rst = 1'b0;
        step();
        check("idle_valid", int'(tw_valid), 0);

        // Plain forward sequence with continuous ready.
        run_seq(-1, -1, -1, 1'b0, nw, nd);
        check("a_words", nw, 32);
        check("a_done", nd, 1);

        // Back-pressure on word (s=0, b=3).
        run_seq(3, -1, -1, 1'b0, nw, nd);
        check("b_words", nw, 32);
        check("b_done", nd, 1);

        // Reset at word 10; no restart without a new start.
        run_seq(-1, 10, -1, 1'b0, nw, nd);
        check("c_done", nd, 0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_valid", int'(tw_valid), 0);
            check("post_rst_done", int'(done), 0);
        end
        run_seq(-1, -1, -1, 1'b0, nw, nd);
        check("c_words", nw, 32);
        check("c_redone", nd, 1);

        // start pulsed while busy is ignored.
        run_seq(-1, -1, 5, 1'b0, nw, nd);
        check("d_words", nw, 32);
        check("d_done", nd, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("d_idle_valid", int'(tw_valid), 0);
        end

`ifdef TW_GEN_INV_EN
        run_seq(-1, -1, -1, 1'b1, nw, nd);
        check("e_words", nw, 32);
        check("e_done", nd, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
